o8_exec_seq: RTL and testbench



---
 rtl/o8_pkg.sv | 45 ++++
 rtl/o8_exec_seq_if.sv | 30 +++
 rtl/o8_alu.sv | 40 ++++
 rtl/o8_exec_seq.sv | 215 +++++++++++++++++++++
 tb/tb_o8_exec_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/o8_pkg.sv
// Shared definitions for the o8 execute stage: command codes, FSM states,
// ALU op selectors and flag bit positions.
package o8_pkg;

    localparam int NREGS  = 8;
    localparam int FLAG_W = 5;

    typedef enum logic [3:0] {
        CMD_MOV = 4'd0,
        CMD_ADD = 4'd1,
        CMD_ADC = 4'd2,
        CMD_SUB = 4'd3,
        CMD_SBB = 4'd4,
        CMD_AND = 4'd5,
        CMD_OR  = 4'd6,
        CMD_XOR = 4'd7,
        CMD_NOT = 4'd8,
        CMD_CMP = 4'd9,
        CMD_SHL = 4'd10
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    localparam logic [2:0] ALU_LEFT  = 3'd0;
    localparam logic [2:0] ALU_RIGHT = 3'd1;
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;

    // flags word layout is {Z, C, O, S, P}
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_P = 0;

    function automatic logic even_parity(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/o8_exec_seq_if.sv
// Decoder-to-execute handshake bundle: request fields, retire pulse and flags.
interface o8_exec_seq_if;
    import o8_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cmd;
    logic [2:0]        req_dst;
    logic [2:0]        req_src_a;
    logic [2:0]        req_src_b;
    logic [7:0]        req_imm;
    logic              req_use_imm;
    logic [2:0]        req_cnt;
    logic              done;
    logic              done_err;
    logic [FLAG_W-1:0] flags;

    modport master (
        output req_valid, req_cmd, req_dst, req_src_a, req_src_b,
               req_imm, req_use_imm, req_cnt,
        input  req_ready, done, done_err, flags
    );

    modport slave (
        input  req_valid, req_cmd, req_dst, req_src_a, req_src_b,
               req_imm, req_use_imm, req_cnt,
        output req_ready, done, done_err, flags
    );

endinterface

// File: rtl/o8_alu.sv
// 8-bit combinational ALU with optional inversion of both inputs and the result.
module o8_alu
    import o8_pkg::*;
(
    input  logic [7:0] i_left,
    input  logic [7:0] i_right,
    input  logic [2:0] i_op,
    input  logic       i_not_left,
    input  logic       i_not_right,
    input  logic       i_not_result,
    input  logic       i_cf_in,
    output logic [7:0] o_result,
    output logic       o_cf_out
);

    logic [7:0] w_l;
    logic [7:0] w_r;
    logic [8:0] w_sum;
    logic [7:0] w_res;
    logic       w_cf;

    always_comb begin
        w_l   = i_not_left  ? ~i_left  : i_left;
        w_r   = i_not_right ? ~i_right : i_right;
        w_sum = {1'b0, w_l} + {1'b0, w_r} + {8'd0, i_cf_in};
        w_res = w_l;
        w_cf  = 1'b0;
        case (i_op)
            ALU_LEFT:  w_res = w_l;
            ALU_RIGHT: w_res = w_r;
            ALU_ADD:   {w_cf, w_res} = w_sum;
            ALU_AND:   w_res = w_l & w_r;
            ALU_XOR:   w_res = w_l ^ w_r;
            default:   w_res = w_l;
        endcase
        o_result = i_not_result ? ~w_res : w_res;
        o_cf_out = w_cf;
    end

endmodule

// File: rtl/o8_exec_seq.sv
// o8 execute-stage sequencer: one op in flight, 8x8 register file,
// command-to-ALU mapping, iterated SHL and flag writeback.
module o8_exec_seq
    import o8_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    o8_exec_seq_if.slave  bus,
    input  logic [2:0]    dbg_idx,
    output logic [7:0]    dbg_data
);

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_cmd;
    logic [2:0]          r_dst;
    logic [2:0]          r_cnt;
    logic [7:0]          r_a;
    logic [7:0]          r_b;
    logic [FLAG_W-1:0]   r_flags;
    logic [FLAG_W-1:0]   w_flags_next;
    logic                r_done;
    logic                r_done_err;
    logic                w_done_next;
    logic                w_err_next;

    logic [NREGS-1:0][7:0] w_regs;
    logic [7:0]          w_rd_a;
    logic [7:0]          w_rd_b;
    logic                w_we;
    logic                w_accept;
    logic                w_upd_zsp;

    logic [2:0]          w_alu_op;
    logic                w_not_l;
    logic                w_not_r;
    logic                w_not_res;
    logic                w_cf_in;
    logic [7:0]          w_alu_left;
    logic [7:0]          w_alu_right;
    logic [7:0]          w_alu_res;
    logic                w_alu_cf;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [7:0] r_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_we && r_dst == 3'(gi)) begin
                    r_q <= w_alu_res;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign w_rd_a   = w_regs[bus.req_src_a];
    assign w_rd_b   = w_regs[bus.req_src_b];
    assign dbg_data = w_regs[dbg_idx];
    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.done      = r_done;
    assign bus.done_err  = r_done_err;
    assign bus.flags     = r_flags;

    o8_alu u_alu (
        .i_left       (w_alu_left),
        .i_right      (w_alu_right),
        .i_op         (w_alu_op),
        .i_not_left   (w_not_l),
        .i_not_right  (w_not_r),
        .i_not_result (w_not_res),
        .i_cf_in      (w_cf_in),
        .o_result     (w_alu_res),
        .o_cf_out     (w_alu_cf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_alu_op     = ALU_LEFT;
        w_not_l      = 1'b0;
        w_not_r      = 1'b0;
        w_not_res    = 1'b0;
        w_cf_in      = 1'b0;
        w_alu_left   = r_a;
        w_alu_right  = r_b;
        w_we         = 1'b0;
        w_upd_zsp    = 1'b0;
        w_flags_next = r_flags;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = (bus.req_cmd == CMD_SHL) ? ST_SHIFT : ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
                case (r_cmd)
                    CMD_MOV: begin
                        w_alu_op = ALU_RIGHT;
                        w_we     = 1'b1;
                    end
                    CMD_ADD, CMD_ADC: begin
                        w_alu_op  = ALU_ADD;
                        w_cf_in   = (r_cmd == CMD_ADC) && r_flags[FLAG_C];
                        w_we      = 1'b1;
                        w_upd_zsp = 1'b1;
                        w_flags_next[FLAG_C] = w_alu_cf;
                        w_flags_next[FLAG_O] = (r_a[7] == r_b[7]) && (w_alu_res[7] != r_a[7]);
                    end
                    CMD_SUB, CMD_SBB, CMD_CMP: begin
                        // a - b computed as a + ~b + 1; carry-out high means no borrow
                        w_alu_op  = ALU_ADD;
                        w_not_r   = 1'b1;
                        w_cf_in   = (r_cmd == CMD_SBB) ? ~r_flags[FLAG_C] : 1'b1;
                        w_we      = (r_cmd != CMD_CMP);
                        w_upd_zsp = 1'b1;
                        w_flags_next[FLAG_C] = ~w_alu_cf;
                        w_flags_next[FLAG_O] = (r_a[7] != r_b[7]) && (w_alu_res[7] != r_a[7]);
                    end
                    CMD_AND, CMD_OR, CMD_XOR: begin
                        w_alu_op  = (r_cmd == CMD_XOR) ? ALU_XOR : ALU_AND;
                        // OR via De Morgan on the AND path
                        w_not_l   = (r_cmd == CMD_OR);
                        w_not_r   = (r_cmd == CMD_OR);
                        w_not_res = (r_cmd == CMD_OR);
                        w_we      = 1'b1;
                        w_upd_zsp = 1'b1;
                        w_flags_next[FLAG_C] = 1'b0;
                        w_flags_next[FLAG_O] = 1'b0;
                    end
                    CMD_NOT: begin
                        w_alu_op  = ALU_LEFT;
                        w_not_res = 1'b1;
                        w_we      = 1'b1;
                        w_upd_zsp = 1'b1;
                    end
                    default: begin
                        w_err_next = 1'b1;
                    end
                endcase
            end

            ST_SHIFT: begin
                w_alu_op    = ALU_ADD;
                w_alu_right = r_a;
                if (r_cnt <= 3'd1) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
                // last doubling step commits; a zero count retires silently
                if (r_cnt == 3'd1) begin
                    w_we      = 1'b1;
                    w_upd_zsp = 1'b1;
                    w_flags_next[FLAG_C] = w_alu_cf;
                    w_flags_next[FLAG_O] = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_upd_zsp) begin
            w_flags_next[FLAG_Z] = (w_alu_res == 8'd0);
            w_flags_next[FLAG_S] = w_alu_res[7];
            w_flags_next[FLAG_P] = even_parity(w_alu_res);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_flags    <= '0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_flags    <= w_flags_next;
            r_done     <= w_done_next;
            r_done_err <= w_err_next;
            if (w_accept) begin
                r_cmd <= bus.req_cmd;
                r_dst <= bus.req_dst;
                r_cnt <= bus.req_cnt;
                r_a   <= w_rd_a;
                r_b   <= bus.req_use_imm ? bus.req_imm : w_rd_b;
            end else if (r_state == ST_SHIFT && r_cnt != 3'd0) begin
                r_a   <= w_alu_res;
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_o8_exec_seq.sv
// Directed, table-driven bench for o8_exec_seq: register/flag results,
// retire latency and ready behaviour, plus reset-during-SHL.
module tb_o8_exec_seq;
    import o8_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_idx = 3'd0;
    logic [7:0] dbg_data;

    o8_exec_seq_if bus();

    o8_exec_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] cmd;
        logic [2:0] dst;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [7:0] imm;
        logic       ui;
        logic [2:0] cnt;
        logic [2:0] creg;
        logic [7:0] val;
        logic [4:0] fl;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] cmd, input logic [2:0] dst,
                                input logic [2:0] sa, input logic [2:0] sb,
                                input logic [7:0] imm, input logic ui,
                                input logic [2:0] cnt, input logic [2:0] creg,
                                input logic [7:0] val, input logic [4:0] fl,
                                input logic err, input int lat);
        vec_t v;
        v.cmd = cmd; v.dst = dst; v.sa = sa; v.sb = sb; v.imm = imm; v.ui = ui;
        v.cnt = cnt; v.creg = creg; v.val = val; v.fl = fl; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_regs_zero(input string nm);
        for (int i = 0; i < NREGS; i++) begin
            dbg_idx = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", nm, i), {24'd0, dbg_data}, 32'd0);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int waitc;
        int lat;
        logic ready_low;
        @(negedge clk);
        bus.req_cmd     = v.cmd;
        bus.req_dst     = v.dst;
        bus.req_src_a   = v.sa;
        bus.req_src_b   = v.sb;
        bus.req_imm     = v.imm;
        bus.req_use_imm = v.ui;
        bus.req_cnt     = v.cnt;
        bus.req_valid   = 1'b1;
        dbg_idx         = v.creg;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) begin
            chk($sformatf("op%0d_accept_timeout", idx), 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        ready_low = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
            if (bus.req_ready) ready_low = 1'b0;
        end
        chk($sformatf("op%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("op%0d_busy_ready_low", idx), {31'd0, ready_low}, 32'd1);
        chk($sformatf("op%0d_ready_at_done", idx), {31'd0, bus.req_ready}, 32'd1);
        chk($sformatf("op%0d_done_err", idx), {31'd0, bus.done_err}, {31'd0, v.err});
        chk($sformatf("op%0d_reg%0d", idx, v.creg), {24'd0, dbg_data}, {24'd0, v.val});
        chk($sformatf("op%0d_flags", idx), {27'd0, bus.flags}, {27'd0, v.fl});
        $display("op %0d cmd=%0d lat=%0d r%0d=%02h flags=%05b err=%0b",
                 idx, v.cmd, lat, v.creg, dbg_data, bus.flags, bus.done_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        bus.req_valid   = 1'b0;
        bus.req_cmd     = '0;
        bus.req_dst     = '0;
        bus.req_src_a   = '0;
        bus.req_src_b   = '0;
        bus.req_imm     = '0;
        bus.req_use_imm = 1'b0;
        bus.req_cnt     = '0;

        //            cmd      dst sa sb imm    ui cnt chk val    flags ZCOSP  err lat
        vecs.push_back(mk(CMD_MOV, 1, 0, 0, 8'h7F, 1, 0, 1, 8'h7F, 5'b00000, 0, 2));
        vecs.push_back(mk(CMD_MOV, 2, 0, 0, 8'h01, 1, 0, 2, 8'h01, 5'b00000, 0, 2));
        vecs.push_back(mk(CMD_ADD, 3, 1, 2, 8'h00, 0, 0, 3, 8'h80, 5'b00110, 0, 2));
        vecs.push_back(mk(CMD_MOV, 1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 5'b00110, 0, 2));
        vecs.push_back(mk(CMD_SUB, 4, 1, 0, 8'h01, 1, 0, 4, 8'hFF, 5'b01011, 0, 2));
        vecs.push_back(mk(CMD_ADC, 6, 2, 0, 8'h01, 1, 0, 6, 8'h03, 5'b00001, 0, 2));
        vecs.push_back(mk(CMD_MOV, 5, 0, 0, 8'h42, 1, 0, 5, 8'h42, 5'b00001, 0, 2));
        vecs.push_back(mk(CMD_CMP, 5, 5, 0, 8'h42, 1, 0, 5, 8'h42, 5'b10001, 0, 2));
        vecs.push_back(mk(CMD_SUB, 0, 1, 0, 8'h01, 1, 0, 0, 8'hFF, 5'b01011, 0, 2));
        vecs.push_back(mk(CMD_SBB, 7, 2, 0, 8'h00, 1, 0, 7, 8'h00, 5'b10001, 0, 2));
        vecs.push_back(mk(CMD_MOV, 1, 0, 0, 8'hF0, 1, 0, 1, 8'hF0, 5'b10001, 0, 2));
        vecs.push_back(mk(CMD_OR,  2, 1, 0, 8'h0F, 1, 0, 2, 8'hFF, 5'b00011, 0, 2));
        vecs.push_back(mk(CMD_AND, 3, 1, 0, 8'h3C, 1, 0, 3, 8'h30, 5'b00001, 0, 2));
        vecs.push_back(mk(CMD_XOR, 4, 1, 0, 8'hF1, 1, 0, 4, 8'h01, 5'b00000, 0, 2));
        vecs.push_back(mk(CMD_MOV, 6, 0, 0, 8'h80, 1, 0, 6, 8'h80, 5'b00000, 0, 2));
        vecs.push_back(mk(CMD_ADD, 7, 6, 6, 8'h00, 0, 0, 7, 8'h00, 5'b11101, 0, 2));
        vecs.push_back(mk(CMD_NOT, 5, 1, 0, 8'h00, 1, 0, 5, 8'h0F, 5'b01101, 0, 2));
        vecs.push_back(mk(4'd12,   5, 1, 0, 8'h33, 1, 0, 5, 8'h0F, 5'b01101, 1, 2));
        vecs.push_back(mk(CMD_SHL, 5, 5, 0, 8'h00, 1, 0, 5, 8'h0F, 5'b01101, 0, 2));
        vecs.push_back(mk(CMD_MOV, 6, 0, 0, 8'h81, 1, 0, 6, 8'h81, 5'b01101, 0, 2));
        vecs.push_back(mk(CMD_SHL, 6, 6, 0, 8'h00, 1, 3, 6, 8'h08, 5'b00000, 0, 4));
        vecs.push_back(mk(CMD_SHL, 1, 1, 0, 8'h00, 1, 1, 1, 8'hE0, 5'b01010, 0, 2));
        vecs.push_back(mk(CMD_MOV, 0, 0, 6, 8'h55, 0, 0, 0, 8'h08, 5'b01010, 0, 2));

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_done_err", {31'd0, bus.done_err}, 32'd0);
        chk("rst_flags", {27'd0, bus.flags}, 32'd0);
        check_all_regs_zero("rst");
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(i, vecs[i]);

        // reset during a long SHL aborts everything
        @(negedge clk);
        bus.req_cmd     = CMD_SHL;
        bus.req_dst     = 3'd2;
        bus.req_src_a   = 3'd2;
        bus.req_use_imm = 1'b1;
        bus.req_cnt     = 3'd7;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midshl_busy", {31'd0, bus.req_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midshl_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midshl_done", {31'd0, bus.done}, 32'd0);
        chk("midshl_flags", {27'd0, bus.flags}, 32'd0);
        check_all_regs_zero("midshl");
        rst_n = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        chk("midshl_no_done", 32'(seen_done), 32'd0);
        $display("reset mid-SHL: ready=%0b flags=%05b done_pulses=%0d",
                 bus.req_ready, bus.flags, seen_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
